// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache controller slice.
//  - default geometry (byte address width, word width, index width)
//  - controller state encoding
//  - line index / tag extraction helpers (width-generic through 64-bit values)
package dcache_pkg;

  localparam int unsigned DCACHE_ADDR_W  = 32;
  localparam int unsigned DCACHE_DATA_W  = 32;
  localparam int unsigned DCACHE_INDEX_W = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Word index within the cache: addr[index_w+1:2].
  function automatic logic [63:0] line_index(input logic [63:0] addr,
                                             input int unsigned index_w);
    return (addr >> 2) & ((64'd1 << index_w) - 64'd1);
  endfunction

  // Tag: everything above the index bits.
  function automatic logic [63:0] line_tag(input logic [63:0] addr,
                                           input int unsigned index_w);
    return addr >> (index_w + 2);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for a direct-mapped, one-word-line cache.
//  clk, rst        clock; synchronous active-high reset clears valid bits only
//  rd_index        lookup index (asynchronous read)
//  rd_valid/tag/data  contents of the addressed line
//  wr_en           single synchronous write port: sets valid and writes tag/data
//  wr_index/tag/data  write port address and contents
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_W = DCACHE_INDEX_W,
  parameter int unsigned TAG_W   = DCACHE_ADDR_W - DCACHE_INDEX_W - 2,
  parameter int unsigned DATA_W  = DCACHE_DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_data
);

  localparam int unsigned LINES = 1 << INDEX_W;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags  [LINES];
  logic [DATA_W-1:0] words [LINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag/data are deliberately not reset; valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index]  <= wr_tag;
      words[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = words[rd_index];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
//  clk, rst        clock; synchronous active-high reset
//  cpu_re/cpu_we   load/store request from exe (store wins)
//  cpu_addr        byte address (bits[1:0] ignored)
//  cpu_wdata       store data
//  cpu_rdata       load data (valid when cpu_re & !cpu_stall)
//  cpu_stall       request not yet complete
//  mem_req/mem_we  backing-memory request (held until mem_ack) and direction
//  mem_addr        word-aligned memory address
//  mem_wdata       store data to memory
//  mem_ack         one-cycle completion pulse
//  mem_rdata       refill data, valid with mem_ack on a read
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_W  = DCACHE_ADDR_W,
  parameter int unsigned DATA_W  = DCACHE_DATA_W,
  parameter int unsigned INDEX_W = DCACHE_INDEX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned TAG_W = ADDR_W - INDEX_W - 2;

  state_t state, next_state;

  logic [INDEX_W-1:0] cpu_index, mem_index, arr_index;
  logic [TAG_W-1:0]   cpu_tag, mem_tag, arr_tag, rd_tag;
  logic [DATA_W-1:0]  rd_data, arr_data, resp_q;
  logic               rd_valid, hit, arr_we;

  assign cpu_index = INDEX_W'(line_index(64'(cpu_addr), INDEX_W));
  assign cpu_tag   = TAG_W'(line_tag(64'(cpu_addr), INDEX_W));
  // The latched request address doubles as the refill target.
  assign mem_index = INDEX_W'(line_index(64'(mem_addr), INDEX_W));
  assign mem_tag   = TAG_W'(line_tag(64'(mem_addr), INDEX_W));

  assign hit = rd_valid && (rd_tag == cpu_tag);

  dcache_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (cpu_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (arr_we),
    .wr_index (arr_index),
    .wr_tag   (arr_tag),
    .wr_data  (arr_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    cpu_stall  = 1'b0;
    cpu_rdata  = '0;
    arr_we     = 1'b0;
    arr_index  = cpu_index;
    arr_tag    = cpu_tag;
    arr_data   = cpu_wdata;
    case (state)
      IDLE: begin
        cpu_rdata = rd_data;
        if (cpu_we) begin
          cpu_stall  = 1'b1;
          arr_we     = hit;   // write hit updates in place; miss does not allocate
          next_state = WRITE;
        end else if (cpu_re && !hit) begin
          cpu_stall  = 1'b1;
          next_state = REFILL;
        end
      end
      REFILL: begin
        cpu_stall = 1'b1;
        arr_index = mem_index;
        arr_tag   = mem_tag;
        arr_data  = mem_rdata;
        if (mem_ack) begin
          arr_we     = 1'b1;
          next_state = DONE;
        end
      end
      WRITE: begin
        cpu_stall = 1'b1;
        if (mem_ack) next_state = DONE;
      end
      DONE: begin
        cpu_rdata  = resp_q;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (rst) arr_we = 1'b0;
  end

  // Memory-side registers follow the transitions chosen above.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      resp_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (next_state != IDLE) begin
            mem_req  <= 1'b1;
            mem_we   <= cpu_we;
            mem_addr <= {cpu_addr[ADDR_W-1:2], 2'b00};
            if (cpu_we) mem_wdata <= cpu_wdata;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            resp_q  <= mem_rdata;
          end
        end
        WRITE: begin
          if (mem_ack) mem_req <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: directed scenarios plus random load/store
// traffic against a behavioural cache/memory model.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_re, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  dcache_ctrl #(.ADDR_W(32), .DATA_W(32), .INDEX_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_re    (cpu_re),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed { bit is_load; logic [31:0] data; } cpu_exp_t;
  typedef struct packed { bit we; logic [31:0] addr; logic [31:0] wdata; } mem_exp_t;

  cpu_exp_t exp_q[$];
  mem_exp_t mem_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: 64 one-word lines plus a sparse backing memory.
  bit          m_valid [64];
  int unsigned m_word  [64];
  logic [31:0] m_data  [64];
  logic [31:0] bmem [int unsigned];

  bit mem_auto     = 1'b1;
  int forced_delay = -1;
  int last_delay   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bmem_rd(input int unsigned w);
    if (bmem.exists(w)) return bmem[w];
    return (w * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // Issue one request (called just after a rising edge), wait for completion.
  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    int unsigned w, idx;
    bit          hit, first_stall;
    int          stalls;
    bit          done;
    w   = addr >> 2;
    idx = w % 64;
    hit = m_valid[idx] && (m_word[idx] == w);
    if (we) begin
      if (hit) m_data[idx] = wdata;
      bmem[w] = wdata;
      mem_q.push_back('{we: 1'b1, addr: w << 2, wdata: wdata});
      exp_q.push_back('{is_load: 1'b0, data: 32'h0});
      first_stall = 1'b1;
    end else if (hit) begin
      exp_q.push_back('{is_load: 1'b1, data: m_data[idx]});
      first_stall = 1'b0;
    end else begin
      m_valid[idx] = 1'b1;
      m_word[idx]  = w;
      m_data[idx]  = bmem_rd(w);
      mem_q.push_back('{we: 1'b0, addr: w << 2, wdata: 32'h0});
      exp_q.push_back('{is_load: 1'b1, data: m_data[idx]});
      first_stall = 1'b1;
    end
    cpu_we    = we;
    cpu_re    = ~we | ($urandom_range(0, 1) == 1);
    cpu_addr  = addr;
    cpu_wdata = wdata;
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (c == 0) chk("first_cycle_stall", 32'(cpu_stall), 32'(first_stall));
      if (!cpu_stall) done = 1'b1;
      else stalls++;
    end
    if (!done) chk("request_timeout", 32'(cpu_stall), 32'h0);
    else if (first_stall) chk("stall_cycles", 32'(stalls), 32'(last_delay + 2));
    @(posedge clk);
    #1;
    cpu_re = 1'b0;
    cpu_we = 1'b0;
  endtask

  // Monitor: every completed CPU request pops one expectation.
  initial begin
    cpu_exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && !cpu_stall && (cpu_re || cpu_we)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_completion", 32'(cpu_re), 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("completion_kind", 32'(cpu_re && !cpu_we), 32'(e.is_load));
          if (e.is_load) chk("load_data", cpu_rdata, e.data);
        end
      end
    end
  end

  // Backing-memory responder with a random wait before the ack pulse.
  initial begin
    mem_exp_t e;
    int       d;
    forever begin
      @(negedge clk);
      if (mem_auto && !rst && mem_req) begin
        if (mem_q.size() == 0) begin
          chk("unexpected_mem_req", 32'(mem_req), 32'h0);
        end else begin
          e = mem_q.pop_front();
          chk("mem_we", 32'(mem_we), 32'(e.we));
          chk("mem_addr", mem_addr, e.addr);
          if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
        end
        d = (forced_delay >= 0) ? forced_delay : int'($urandom_range(0, 3));
        forced_delay = -1;
        last_delay   = d;
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          chk("mem_req_held", 32'(mem_req), 32'h1);
        end
        mem_rdata = bmem_rd(mem_addr >> 2);
        mem_ack   = 1'b1;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        chk("mem_req_drop", 32'(mem_req), 32'h0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    rst = 1'b1; cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_mem_req", 32'(mem_req), 32'h0);
    chk("reset_mem_we", 32'(mem_we), 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_mem_wdata", mem_wdata, 32'h0);
    chk("reset_stall", 32'(cpu_stall), 32'h0);
    @(posedge clk); #1;

    // Directed: refill, hit, store hit, store miss (no allocate), eviction.
    bmem[32'h40 >> 2] = 32'hDEADBEEF;
    forced_delay = 3;
    do_req(1'b0, 32'h40, 32'h0);
    do_req(1'b0, 32'h40, 32'h0);
    do_req(1'b1, 32'h40, 32'h12345678);
    do_req(1'b0, 32'h40, 32'h0);
    do_req(1'b1, 32'h1040, 32'hCAFEF00D);
    do_req(1'b0, 32'h40, 32'h0);
    do_req(1'b0, 32'h1040, 32'h0);
    do_req(1'b0, 32'h43, 32'h0);

    // Random traffic over a small footprint to force hits and aliasing.
    for (int n = 0; n < 300; n++) begin
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      do_req($urandom_range(0, 2) == 0, a, $urandom);
    end

    // Reset in the middle of a refill; a late ack must be ignored.
    mem_auto = 1'b0;
    cpu_re = 1'b1; cpu_addr = 32'h80;
    @(negedge clk);
    chk("rst_test_stall", 32'(cpu_stall), 32'h1);
    @(negedge clk);
    chk("rst_test_req", 32'(mem_req), 32'h1);
    chk("rst_test_addr", mem_addr, 32'h80);
    chk("rst_test_we", 32'(mem_we), 32'h0);
    rst = 1'b1; cpu_re = 1'b0;
    @(negedge clk);
    chk("rst_abandon_req", 32'(mem_req), 32'h0);
    chk("rst_abandon_stall", 32'(cpu_stall), 32'h0);
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h0BADBAD0;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack_req", 32'(mem_req), 32'h0);
    chk("late_ack_stall", 32'(cpu_stall), 32'h0);
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    mem_auto = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 32'h40, 32'h0);
    do_req(1'b0, 32'h40, 32'h0);

    repeat (3) @(negedge clk);
    chk("exp_queue_drained", 32'(exp_q.size()), 32'h0);
    chk("mem_queue_drained", 32'(mem_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
